// File: rtl/lsu_ex.sv
// lsu_ex -- execute stage of the load/store unit.
//
// Takes the registered decode fields from the ID/EX register plus the
// register-file operands, forms the effective address, rejects misaligned
// or illegal-size accesses, and drives one valid/ready memory request per
// op. Loads then wait for the response, which is lane-shifted and extended
// into a one-cycle writeback strobe. stall_out holds upstream while busy.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   is_load_in, zero_ext_in,
//   is_nop_in, size_in, rd_in,
//   imm_in, rs1_data_in,
//   rs2_data_in                     decoded op and operands (held while stalled)
//   stall_out                       upstream must hold its inputs
//   mem_req_valid/ready/we/addr/
//   be/wdata                        memory request channel
//   mem_rsp_valid/rdata             load response channel
//   wb_valid/wb_rd/wb_data          one-cycle load writeback
//   misalign_out                    one-cycle misaligned/illegal-size flag
module lsu_ex #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            is_load_in,
  input  logic            zero_ext_in,
  input  logic            is_nop_in,
  input  logic [1:0]      size_in,
  input  logic [4:0]      rd_in,
  input  logic [11:0]     imm_in,
  input  logic [XLEN-1:0] rs1_data_in,
  input  logic [XLEN-1:0] rs2_data_in,
  output logic            stall_out,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic            mem_req_we,
  output logic [XLEN-1:0] mem_req_addr,
  output logic [3:0]      mem_req_be,
  output logic [XLEN-1:0] mem_req_wdata,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rsp_rdata,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            misalign_out
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_t            state_q;
  logic              is_load_q;
  logic              zero_ext_q;
  logic [1:0]        size_q;
  logic [4:0]        rd_q;
  logic              req_valid_q;
  logic              req_we_q;
  logic [XLEN-1:0]   req_addr_q;
  logic [3:0]        req_be_q;
  logic [XLEN-1:0]   req_wdata_q;
  logic              wb_valid_q;
  logic [4:0]        wb_rd_q;
  logic [XLEN-1:0]   wb_data_q;
  logic              misalign_q;

  logic [XLEN-1:0]   addr_d;
  logic              misalign_d;
  logic [3:0]        be_d;
  logic [XLEN-1:0]   wdata_d;
  logic [XLEN-1:0]   shifted;
  logic [XLEN-1:0]   load_data_d;

  // Request formation from the incoming op.
  // NOTE: every signal assigned in always_comb gets a default first so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    addr_d     = rs1_data_in + {{(XLEN-12){imm_in[11]}}, imm_in};
    misalign_d = 1'b0;
    be_d       = 4'b1111;
    wdata_d    = rs2_data_in;
    case (size_in)
      SZ_BYTE: begin
        be_d    = 4'b0001 << addr_d[1:0];
        wdata_d = {4{rs2_data_in[7:0]}};
      end
      SZ_HALF: begin
        misalign_d = addr_d[0];
        be_d       = 4'b0011 << addr_d[1:0];
        wdata_d    = {2{rs2_data_in[15:0]}};
      end
      SZ_WORD: misalign_d = (addr_d[1:0] != 2'b00);
      default: misalign_d = 1'b1;  // reserved size is always illegal
    endcase
  end

  // Load alignment uses the address held in the request register, which
  // is still valid while the response is awaited.
  always_comb begin
    shifted     = mem_rsp_rdata >> {req_addr_q[1:0], 3'b000};
    load_data_d = shifted;
    case (size_q)
      SZ_BYTE: load_data_d = zero_ext_q ? {{(XLEN-8){1'b0}}, shifted[7:0]}
                                        : {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      SZ_HALF: load_data_d = zero_ext_q ? {{(XLEN-16){1'b0}}, shifted[15:0]}
                                        : {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      default: load_data_d = shifted;
    endcase
  end

  // Single FSM process with registered outputs.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      is_load_q   <= 1'b0;
      zero_ext_q  <= 1'b0;
      size_q      <= 2'b00;
      rd_q        <= 5'd0;
      req_valid_q <= 1'b0;
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      req_be_q    <= 4'b0000;
      req_wdata_q <= '0;
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= 5'd0;
      wb_data_q   <= '0;
      misalign_q  <= 1'b0;
    end else begin
      // Strobes default low; only the cycle that raises them sets them.
      wb_valid_q <= 1'b0;
      misalign_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!is_nop_in) begin
            if (misalign_d) begin
              misalign_q <= 1'b1;
            end else begin
              is_load_q   <= is_load_in;
              zero_ext_q  <= zero_ext_in;
              size_q      <= size_in;
              rd_q        <= rd_in;
              req_valid_q <= 1'b1;
              req_we_q    <= ~is_load_in;
              req_addr_q  <= addr_d;
              req_be_q    <= be_d;
              req_wdata_q <= wdata_d;
              state_q     <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (mem_req_ready) begin
            req_valid_q <= 1'b0;
            state_q     <= is_load_q ? S_RESP : S_IDLE;
          end
        end
        S_RESP: begin
          if (mem_rsp_valid) begin
            // A load to x0 completes silently.
            if (rd_q != 5'd0) begin
              wb_valid_q <= 1'b1;
              wb_rd_q    <= rd_q;
              wb_data_q  <= load_data_d;
            end
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign stall_out     = (state_q != S_IDLE);
  assign mem_req_valid = req_valid_q;
  assign mem_req_we    = req_we_q;
  assign mem_req_addr  = req_addr_q;
  assign mem_req_be    = req_be_q;
  assign mem_req_wdata = req_wdata_q;
  assign wb_valid      = wb_valid_q;
  assign wb_rd         = wb_rd_q;
  assign wb_data       = wb_data_q;
  assign misalign_out  = misalign_q;

endmodule

// File: tb/tb_lsu_ex.sv
// Directed self-checking bench for lsu_ex. Inputs change 1 ns after the
// rising edge and outputs are compared at that same point.
module tb_lsu_ex;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        is_load_in, zero_ext_in, is_nop_in;
  logic [1:0]  size_in;
  logic [4:0]  rd_in;
  logic [11:0] imm_in;
  logic [31:0] rs1_data_in, rs2_data_in;
  logic        stall_out, mem_req_valid, mem_req_ready, mem_req_we;
  logic [31:0] mem_req_addr, mem_req_wdata, mem_rsp_rdata, wb_data;
  logic [3:0]  mem_req_be;
  logic        mem_rsp_valid, wb_valid, misalign_out;
  logic [4:0]  wb_rd;

  int checks   = 0;
  int failures = 0;

  lsu_ex dut (
    .clk(clk), .rst_n(rst_n),
    .is_load_in(is_load_in), .zero_ext_in(zero_ext_in), .is_nop_in(is_nop_in),
    .size_in(size_in), .rd_in(rd_in), .imm_in(imm_in),
    .rs1_data_in(rs1_data_in), .rs2_data_in(rs2_data_in),
    .stall_out(stall_out),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
    .mem_req_be(mem_req_be), .mem_req_wdata(mem_req_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .misalign_out(misalign_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic ld, input logic zx, input logic [1:0] sz,
                        input logic [4:0] rd, input logic [31:0] rs1,
                        input logic [11:0] imm, input logic [31:0] rs2);
    is_nop_in   = 1'b0;
    is_load_in  = ld;
    zero_ext_in = zx;
    size_in     = sz;
    rd_in       = rd;
    rs1_data_in = rs1;
    imm_in      = imm;
    rs2_data_in = rs2;
  endtask

  // Load with ready and response on their first possible cycles.
  task automatic do_load(input string tag, input logic zx, input logic [1:0] sz,
                         input logic [4:0] rd, input logic [31:0] rs1,
                         input logic [11:0] imm, input logic [31:0] rdata,
                         input logic [31:0] exp_addr, input logic [3:0] exp_be,
                         input logic [31:0] exp_data);
    set_op(1'b1, zx, sz, rd, rs1, imm, 32'h0);
    mem_req_ready = 1'b1;
    tick();
    is_nop_in = 1'b1;
    check({tag, "_req_valid"}, {31'b0, mem_req_valid}, 32'd1);
    check({tag, "_addr"}, mem_req_addr, exp_addr);
    check({tag, "_be"}, {28'b0, mem_req_be}, {28'b0, exp_be});
    check({tag, "_we"}, {31'b0, mem_req_we}, 32'd0);
    check({tag, "_stall_req"}, {31'b0, stall_out}, 32'd1);
    tick();
    check({tag, "_valid_drop"}, {31'b0, mem_req_valid}, 32'd0);
    check({tag, "_stall_resp"}, {31'b0, stall_out}, 32'd1);
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = rdata;
    tick();
    mem_rsp_valid = 1'b0;
    check({tag, "_wb_valid"}, {31'b0, wb_valid}, (rd != 5'd0) ? 32'd1 : 32'd0);
    if (rd != 5'd0) begin
      check({tag, "_wb_rd"}, {27'b0, wb_rd}, {27'b0, rd});
      check({tag, "_wb_data"}, wb_data, exp_data);
    end
    check({tag, "_stall_idle"}, {31'b0, stall_out}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    is_nop_in = 1'b1; is_load_in = 1'b0; zero_ext_in = 1'b0; size_in = 2'b00;
    rd_in = 5'd0; imm_in = 12'h0; rs1_data_in = 32'h0; rs2_data_in = 32'h0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = 32'h0;

    // Reset state.
    #12;
    check("rst_stall", {31'b0, stall_out}, 32'd0);
    check("rst_req_valid", {31'b0, mem_req_valid}, 32'd0);
    check("rst_addr", mem_req_addr, 32'h0);
    check("rst_be", {28'b0, mem_req_be}, 32'h0);
    check("rst_wdata", mem_req_wdata, 32'h0);
    check("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
    check("rst_wb_data", wb_data, 32'h0);
    check("rst_misalign", {31'b0, misalign_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Word load 0x1000 + 4.
    do_load("ldw", 1'b0, 2'b10, 5'd5, 32'h1000, 12'h004, 32'hDEADBEEF,
            32'h1004, 4'b1111, 32'hDEADBEEF);
    tick();
    check("ldw_wb_pulse_end", {31'b0, wb_valid}, 32'd0);

    // Byte loads at 0x1003, sign- and zero-extended.
    do_load("lbs", 1'b0, 2'b00, 5'd6, 32'h1000, 12'h003, 32'h80123456,
            32'h1003, 4'b1000, 32'hFFFFFF80);
    do_load("lbu", 1'b1, 2'b00, 5'd7, 32'h1000, 12'h003, 32'h80123456,
            32'h1003, 4'b1000, 32'h00000080);
    // Half load at 0x1002, sign-extended from bit 15 of the upper half.
    do_load("lhs", 1'b0, 2'b01, 5'd8, 32'h1000, 12'h002, 32'h9ABC1234,
            32'h1002, 4'b1100, 32'hFFFF9ABC);
    // Word load ignores zero_ext.
    do_load("lwz", 1'b1, 2'b10, 5'd9, 32'h1000, 12'h000, 32'h87654321,
            32'h1000, 4'b1111, 32'h87654321);

    // Half store with ready held low for 3 cycles.
    set_op(1'b0, 1'b0, 2'b01, 5'd0, 32'h2000, 12'hFFE, 32'h1234ABCD);
    mem_req_ready = 1'b0;
    tick();
    is_nop_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("sh_valid", {31'b0, mem_req_valid}, 32'd1);
      check("sh_addr", mem_req_addr, 32'h1FFE);
      check("sh_be", {28'b0, mem_req_be}, 32'hC);
      check("sh_wdata", mem_req_wdata, 32'hABCDABCD);
      check("sh_we", {31'b0, mem_req_we}, 32'd1);
      check("sh_stall", {31'b0, stall_out}, 32'd1);
      if (i == 2) mem_req_ready = 1'b1;
      tick();
    end
    mem_req_ready = 1'b0;
    check("sh_valid_drop", {31'b0, mem_req_valid}, 32'd0);
    check("sh_idle", {31'b0, stall_out}, 32'd0);
    check("sh_no_wb", {31'b0, wb_valid}, 32'd0);
    check("sh_addr_held", mem_req_addr, 32'h1FFE);

    // Misaligned word load at 0x1002.
    set_op(1'b1, 1'b0, 2'b10, 5'd3, 32'h1000, 12'h002, 32'h0);
    tick();
    is_nop_in = 1'b1;
    check("mis_w_flag", {31'b0, misalign_out}, 32'd1);
    check("mis_w_valid", {31'b0, mem_req_valid}, 32'd0);
    check("mis_w_stall", {31'b0, stall_out}, 32'd0);
    tick();
    check("mis_w_pulse_end", {31'b0, misalign_out}, 32'd0);
    // Reserved size at an aligned address.
    set_op(1'b1, 1'b0, 2'b11, 5'd3, 32'h1000, 12'h000, 32'h0);
    tick();
    is_nop_in = 1'b1;
    check("mis_sz_flag", {31'b0, misalign_out}, 32'd1);
    check("mis_sz_valid", {31'b0, mem_req_valid}, 32'd0);
    check("mis_sz_stall", {31'b0, stall_out}, 32'd0);
    tick();
    check("mis_sz_pulse_end", {31'b0, misalign_out}, 32'd0);

    // Load to x0, then a nop with a stray response, then a byte store.
    mem_req_ready = 1'b1;
    do_load("ld0", 1'b0, 2'b10, 5'd0, 32'h1000, 12'h000, 32'h11111111,
            32'h1000, 4'b1111, 32'h0);
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 32'h22222222;
    tick();
    mem_rsp_valid = 1'b0;
    check("stray_wb", {31'b0, wb_valid}, 32'd0);
    check("stray_stall", {31'b0, stall_out}, 32'd0);
    check("stray_req", {31'b0, mem_req_valid}, 32'd0);
    set_op(1'b0, 1'b0, 2'b00, 5'd0, 32'h3000, 12'h001, 32'h00000055);
    tick();
    is_nop_in = 1'b1;
    check("sb_valid", {31'b0, mem_req_valid}, 32'd1);
    check("sb_addr", mem_req_addr, 32'h3001);
    check("sb_be", {28'b0, mem_req_be}, 32'h2);
    check("sb_wdata", mem_req_wdata, 32'h55555555);
    tick();
    check("sb_done", {31'b0, stall_out}, 32'd0);

    // Reset asserted while waiting in RESP.
    set_op(1'b1, 1'b0, 2'b10, 5'd4, 32'h1000, 12'h008, 32'h0);
    tick();
    is_nop_in = 1'b1;
    tick();
    check("rr_in_resp", {31'b0, stall_out}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rr_stall_drop", {31'b0, stall_out}, 32'd0);
    check("rr_req_valid", {31'b0, mem_req_valid}, 32'd0);
    check("rr_addr_clr", mem_req_addr, 32'h0);
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 32'h33333333;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    mem_rsp_valid = 1'b0;
    check("rr_no_wb", {31'b0, wb_valid}, 32'd0);
    check("rr_idle", {31'b0, stall_out}, 32'd0);
    tick();
    check("rr_no_wb_late", {31'b0, wb_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsu_ex.md
Name: lsu_ex

Overview:
Execute stage of the load/store unit, directly downstream of the LSU ID/EX pipeline register. Consumes the registered decode fields (load/store, size, zero-extend, nop, rd, imm) plus register-file operand values. Forms the effective address, checks alignment, and runs a valid/ready memory request. For loads it waits for the response, then aligns and extends the data and presents a one-cycle writeback to the EX/WB stage. While busy it stalls upstream.

Parameters:
XLEN, 32, data and address width; only 32 is supported (byte lanes fixed at 4).

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
is_load_in  in  1  1 = load, 0 = store
zero_ext_in  in  1  load: 1 = zero-extend, 0 = sign-extend
is_nop_in  in  1  1 = no operation this cycle
size_in  in  2  00 byte, 01 half, 10 word, 11 reserved
rd_in  in  5  load destination register
imm_in  in  12  signed address offset
rs1_data_in  in  XLEN  base address operand
rs2_data_in  in  XLEN  store data operand
stall_out  out  1  upstream must hold its inputs
mem_req_valid  out  1  memory request valid
mem_req_ready  in  1  memory accepts request
mem_req_we  out  1  1 = write
mem_req_addr  out  XLEN  byte address
mem_req_be  out  4  byte enables
mem_req_wdata  out  XLEN  lane-replicated store data
mem_rsp_valid  in  1  load response valid
mem_rsp_rdata  in  XLEN  aligned 32-bit word containing the addressed data
wb_valid  out  1  one-cycle writeback strobe
wb_rd  out  5  writeback register
wb_data  out  XLEN  extended load result
misalign_out  out  1  one-cycle misaligned/illegal-size flag

Behaviour:
- Reset (rst_n low, takes effect immediately): state IDLE.
  - All outputs 0, including stall_out, mem_req_valid, wb_valid and misalign_out.
  - Any in-flight transaction is abandoned; a response arriving after reset is ignored.
- Address: addr = rs1_data_in + sign_extend(imm_in), modulo 2^32.
- Misaligned conditions: half with addr[0]=1; word with addr[1:0]!=0; size 11 always.
- FSM states: IDLE, REQ, RESP. stall_out = (state != IDLE), driven from registered state.
- IDLE:
  - If is_nop_in=0, the op is captured at the rising edge.
  - Aligned op: mem_req_* registers load from the captured op; next state REQ.
  - Misaligned op: no request is issued; misalign_out=1 for exactly the next cycle; state stays IDLE.
  - If is_nop_in=1: nothing is captured.
- REQ:
  - mem_req_valid=1; all mem_req_* fields are held stable until mem_req_ready=1.
  - On handshake, mem_req_valid drops the next cycle.
  - Store: next state IDLE; no response is expected.
  - Load: next state RESP.
- RESP:
  - Waits for mem_rsp_valid. mem_rsp_valid outside RESP is ignored.
  - On the edge where mem_rsp_valid=1: wb_valid=1 for exactly the next cycle with registered wb_rd/wb_data; next state IDLE.
  - If rd=0, wb_valid stays 0 but the FSM still returns to IDLE.
- Byte enables:
  - byte: 4'b0001 << addr[1:0]
  - half: 4'b0011 << addr[1:0]
  - word: 4'b1111
- Store wdata:
  - byte: {4{rs2[7:0]}}
  - half: {2{rs2[15:0]}}
  - word: rs2
- Load data:
  - shifted = mem_rsp_rdata >> (8*addr[1:0]).
  - Take low 8/16/32 bits of shifted.
  - zero_ext=1: zero-fill upper bits; otherwise sign-fill from the top bit of the field.
  - zero_ext is ignored for word loads.
- Latency:
  - Store: request valid the cycle after capture.
  - Load: wb_valid earliest 3 cycles after capture (ready and response each on their first possible cycle).
- Back-to-back ops: the next op is accepted in the first IDLE cycle; upstream holds it while stall_out=1. wb_valid and capture of a new op may coincide in that cycle.
- Outputs other than wb_*/misalign_out retain their last values when not strobed; wb_valid/misalign_out are 0 otherwise.

Test Plan:
- Reset: hold rst_n=0 → all outputs 0. Assert rst_n=0 while in RESP → mem_req_valid/stall_out drop immediately; no wb_valid after release.
- Word load, rs1=0x1000, imm=0x004, ready=1, rsp rdata=0xDEADBEEF next cycle → req addr 0x1004, be=1111, we=0; wb_valid pulse with wb_data=0xDEADBEEF, rd echoed; stall_out high for 2 cycles.
- Byte loads at addr 0x1003 with rdata=0x80xxxxxx: sign-extend → wb_data=0xFFFFFF80; zero_ext=1 → 0x00000080.
- Half store, rs1=0x2000, imm=0xFFE (-2), rs2=0x1234ABCD, ready held 0 for 3 cycles → addr 0x1FFE, be=1100, wdata=0xABCDABCD stable until ready; stall_out high throughout; IDLE after handshake.
- Misaligned word load at 0x1002, and size=11 → misalign_out 1-cycle pulse, mem_req_valid never asserted, stall_out stays 0.
- Load to rd=0 followed immediately by a nop then a store → no wb_valid; store request issued the cycle after the first IDLE cycle; stray mem_rsp_valid in IDLE ignored.
